// File: rtl/regfile_pkg.sv
// Shared defaults and derived constants for the dual-write register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_ADDR  = 0;

  // Register count always covers the full address space.
  function automatic int nreg(input int addr_w);
    return 1 << addr_w;
  endfunction

  localparam int NREG_DEF = nreg(ADDR_W_DEF);

  // Source selected for a forwarded read.
  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_P0   = 2'd1,
    FWD_P1   = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set by a reservation, cleared by a write on either port.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREG   = nreg(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              wen0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic              wen1,
  input  logic [ADDR_W-1:0] waddr1,
  output logic [NREG-1:0]   busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    busy_d = busy_q;
    for (int i = 1; i < NREG; i++) begin
      if ((wen0 && waddr0 == ADDR_W'(i)) || (wen1 && waddr1 == ADDR_W'(i)))
        busy_d[i] = 1'b0;
      // Set after clear: a newly issued producer outranks the retiring one.
      if (rsv_en && rsv_addr == ADDR_W'(i))
        busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_2w_sb.sv
// Two-write / two-read register file with busy scoreboard and debug port.
// Optional same-cycle write forwarding: define REGFILE_WRITE_BYPASS_EN.
module regfile_2w_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              wen1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] debug_sel,
  output logic [DATA_W-1:0] debug_out,
  output logic              wr_conflict
);

  localparam int NREG = nreg(ADDR_W);
  localparam logic [ADDR_W-1:0] R0 = ADDR_W'(ZERO_ADDR);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic              wr_conflict_q;
  logic              wr_conflict_d;
  logic [NREG-1:0]   busy_vec;

  // Writes and reservations to r0 are dropped at the source.
  logic we0, we1, rsv;
  assign we0 = wen0   && (waddr0   != R0);
  assign we1 = wen1   && (waddr1   != R0);
  assign rsv = rsv_en && (rsv_addr != R0);

  always_comb begin
    regs_d = regs_q;
    if (we0) regs_d[waddr0] = wdata0;
    if (we1) regs_d[waddr1] = wdata1;
    regs_d[0] = '0;
    wr_conflict_d = we0 && we1 && (waddr0 == waddr1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the array is reset because decode depends on cleared registers; plain RAMs stay unreset.
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREG   (NREG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .rsv_en   (rsv),
    .rsv_addr (rsv_addr),
    .wen0     (we0),
    .waddr0   (waddr0),
    .wen1     (we1),
    .waddr1   (waddr1),
    .busy     (busy_vec)
  );

  logic [DATA_W-1:0] arr_a, arr_b;
  assign arr_a     = (raddr_a   == R0) ? '0 : regs_q[raddr_a];
  assign arr_b     = (raddr_b   == R0) ? '0 : regs_q[raddr_b];
  assign debug_out = (debug_sel == R0) ? '0 : regs_q[debug_sel];

`ifdef REGFILE_WRITE_BYPASS_EN
  function automatic fwd_sel_e fwd_src(input logic [ADDR_W-1:0] ra);
    if (we1 && waddr1 == ra)      return FWD_P1;
    else if (we0 && waddr0 == ra) return FWD_P0;
    else                          return FWD_NONE;
  endfunction

  fwd_sel_e sel_a, sel_b;
  assign sel_a = fwd_src(raddr_a);
  assign sel_b = fwd_src(raddr_b);

  always_comb begin
    rdata_a = arr_a;
    rdata_b = arr_b;
    busy_a  = busy_vec[raddr_a];
    busy_b  = busy_vec[raddr_b];
    unique case (sel_a)
      FWD_P1:  rdata_a = wdata1;
      FWD_P0:  rdata_a = wdata0;
      default: ;
    endcase
    unique case (sel_b)
      FWD_P1:  rdata_b = wdata1;
      FWD_P0:  rdata_b = wdata0;
      default: ;
    endcase
    // A register retiring this cycle is free unless a new producer claims it.
    if (sel_a != FWD_NONE) busy_a = rsv && (rsv_addr == raddr_a);
    if (sel_b != FWD_NONE) busy_b = rsv && (rsv_addr == raddr_b);
  end
`else
  assign rdata_a = arr_a;
  assign rdata_b = arr_b;
  assign busy_a  = busy_vec[raddr_a];
  assign busy_b  = busy_vec[raddr_b];
`endif

  assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_regfile_2w_sb.sv
// Directed scoreboard bench for regfile_2w_sb: stimulus queues expectations, a negedge monitor checks them.
module tb_regfile_2w_sb;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          wen0, wen1, rsv_en;
  logic [AW-1:0] waddr0, waddr1, raddr_a, raddr_b, rsv_addr, debug_sel;
  logic [DW-1:0] wdata0, wdata1;
  logic [DW-1:0] rdata_a, rdata_b, debug_out;
  logic          busy_a, busy_b, wr_conflict;

  regfile_2w_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .wen0        (wen0),
    .waddr0      (waddr0),
    .wdata0      (wdata0),
    .wen1        (wen1),
    .waddr1      (waddr1),
    .wdata1      (wdata1),
    .raddr_a     (raddr_a),
    .raddr_b     (raddr_b),
    .rdata_a     (rdata_a),
    .rdata_b     (rdata_b),
    .busy_a      (busy_a),
    .busy_b      (busy_b),
    .rsv_en      (rsv_en),
    .rsv_addr    (rsv_addr),
    .debug_sel   (debug_sel),
    .debug_out   (debug_out),
    .wr_conflict (wr_conflict)
  );

  always #5 clk = ~clk;

  typedef enum int {S_RDA, S_RDB, S_BSA, S_BSB, S_DBG, S_CNF} sig_e;
  typedef struct {
    int            cyc;
    sig_e          sig;
    logic [DW-1:0] exp;
    string         name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] sample(input sig_e s);
    case (s)
      S_RDA:   return rdata_a;
      S_RDB:   return rdata_b;
      S_BSA:   return {{(DW-1){1'b0}}, busy_a};
      S_BSB:   return {{(DW-1){1'b0}}, busy_b};
      S_DBG:   return debug_out;
      default: return {{(DW-1){1'b0}}, wr_conflict};
    endcase
  endfunction

  // Monitor: every negedge, compare all expectations queued for this cycle.
  exp_t          e;
  logic [DW-1:0] act;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e   = q.pop_front();
      act = sample(e.sig);
      n_checks++;
      if (act === e.exp) n_pass++;
      else $display("FAIL %s (cycle %0d): got %h expected %h", e.name, cyc, act, e.exp);
    end
  end

  task automatic expect_v(input sig_e s, input logic [DW-1:0] v, input string name);
    exp_t x;
    x.cyc = cyc; x.sig = s; x.exp = v; x.name = name;
    q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen0 = 0; waddr0 = '0; wdata0 = '0;
    wen1 = 0; waddr1 = '0; wdata1 = '0;
    rsv_en = 0; rsv_addr = '0;
    raddr_a = '0; raddr_b = '0; debug_sel = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    step();
    step();

    // Post-reset state
    rst = 1'b0;
    raddr_a = 5; raddr_b = 6; debug_sel = 5;
    expect_v(S_RDA, 0, "reset_rdata_a");
    expect_v(S_BSB, 0, "reset_busy_b");
    expect_v(S_CNF, 0, "reset_conflict");
    expect_v(S_DBG, 0, "reset_debug");

    // r5 <- 0x1234 and reserve r6
    wen0 = 1; waddr0 = 5; wdata0 = 32'h1234;
    rsv_en = 1; rsv_addr = 6;
    step();

    // Reset overrides a write to r5 and drops the r6 reservation
    idle();
    rst = 1'b1;
    wen0 = 1; waddr0 = 5; wdata0 = 32'hFFFF;
    raddr_b = 6; debug_sel = 5;
    expect_v(S_DBG, 32'h1234, "pre_rst_r5");
    expect_v(S_BSB, 1, "pre_rst_busy_r6");
    step();
    rst = 1'b0;
    idle();
    raddr_a = 5; raddr_b = 6; debug_sel = 5;
    expect_v(S_RDA, 0, "rst_over_write_r5");
    expect_v(S_DBG, 0, "rst_over_write_dbg");
    expect_v(S_BSB, 0, "rst_drops_rsv");
    expect_v(S_CNF, 0, "rst_conflict");

    // Dual write to different registers
    wen0 = 1; waddr0 = 3; wdata0 = 32'hAAAA_0000;
    wen1 = 1; waddr1 = 7; wdata1 = 32'h0000_5555;
    raddr_a = 3; raddr_b = 7;
`ifdef REGFILE_WRITE_BYPASS_EN
    expect_v(S_RDA, 32'hAAAA_0000, "dual_fwd_a");
    expect_v(S_RDB, 32'h0000_5555, "dual_fwd_b");
`else
    expect_v(S_RDA, 0, "dual_old_a");
    expect_v(S_RDB, 0, "dual_old_b");
`endif
    step();
    idle();
    raddr_a = 3; raddr_b = 7;
    expect_v(S_RDA, 32'hAAAA_0000, "dual_r3");
    expect_v(S_RDB, 32'h0000_5555, "dual_r7");
    expect_v(S_CNF, 0, "dual_no_conflict");

    // Same-address write: port 1 wins, one-cycle conflict pulse
    wen0 = 1; waddr0 = 9; wdata0 = 32'h11;
    wen1 = 1; waddr1 = 9; wdata1 = 32'h22;
    step();
    idle();
    raddr_a = 9;
    expect_v(S_RDA, 32'h22, "conflict_p1_wins");
    expect_v(S_CNF, 1, "conflict_pulse");
    step();
    raddr_a = 9;
    expect_v(S_CNF, 0, "conflict_one_cycle");
    expect_v(S_RDA, 32'h22, "conflict_hold");

    // r0: writes on both ports and a reserve are ignored, no conflict
    wen0 = 1; waddr0 = 0; wdata0 = 32'hDEAD;
    wen1 = 1; waddr1 = 0; wdata1 = 32'hDEAD;
    rsv_en = 1; rsv_addr = 0;
    step();
    idle();
    expect_v(S_RDA, 0, "r0_rdata_a");
    expect_v(S_RDB, 0, "r0_rdata_b");
    expect_v(S_BSA, 0, "r0_busy_a");
    expect_v(S_DBG, 0, "r0_debug");
    expect_v(S_CNF, 0, "r0_no_conflict");

    // Scoreboard: reserve r4, reserve again, then clear by port 0 write
    rsv_en = 1; rsv_addr = 4;
    step();
    raddr_a = 4;
    expect_v(S_BSA, 1, "sb_rsv_set");
    step();
    idle();
    raddr_a = 4;
    expect_v(S_BSA, 1, "sb_rsv_again");
    wen0 = 1; waddr0 = 4; wdata0 = 32'h99;
`ifdef REGFILE_WRITE_BYPASS_EN
    expect_v(S_BSA, 0, "sb_clear_fwd");
`else
    expect_v(S_BSA, 1, "sb_clear_pending");
`endif
    step();
    idle();
    raddr_a = 4;
    expect_v(S_BSA, 0, "sb_cleared");
    expect_v(S_RDA, 32'h99, "sb_r4_data");

    // Reserve and write r4 in the same cycle: stays busy
    rsv_en = 1; rsv_addr = 4;
    wen1 = 1; waddr1 = 4; wdata1 = 32'h100;
`ifdef REGFILE_WRITE_BYPASS_EN
    expect_v(S_BSA, 1, "sb_rsv_wr_fwd");
`else
    expect_v(S_BSA, 0, "sb_rsv_wr_old");
`endif
    step();
    idle();
    raddr_a = 4;
    expect_v(S_BSA, 1, "sb_rsv_wins");
    expect_v(S_RDA, 32'h100, "sb_r4_data2");

    // Port 1 write also clears busy
    wen1 = 1; waddr1 = 4; wdata1 = 32'h101;
    step();
    idle();
    raddr_a = 4;
    expect_v(S_BSA, 0, "sb_p1_clear");

    // Forwarding: r12 old 0x55, then port 1 writes 0x77 while reading
    wen0 = 1; waddr0 = 12; wdata0 = 32'h55;
    step();
    idle();
    wen1 = 1; waddr1 = 12; wdata1 = 32'h77;
    raddr_b = 12; debug_sel = 12;
`ifdef REGFILE_WRITE_BYPASS_EN
    expect_v(S_RDB, 32'h77, "bypass_fwd");
`else
    expect_v(S_RDB, 32'h55, "bypass_off_old");
`endif
    expect_v(S_DBG, 32'h55, "bypass_debug_old");
    step();
    idle();
    raddr_b = 12;
    expect_v(S_RDB, 32'h77, "bypass_next");

    // Top address, all-ones data
    wen1 = 1; waddr1 = 31; wdata1 = 32'hFFFF_FFFF;
    step();
    idle();
    raddr_b = 31; debug_sel = 31;
    expect_v(S_RDB, 32'hFFFF_FFFF, "r31_rdata");
    expect_v(S_DBG, 32'hFFFF_FFFF, "r31_debug");

    // Let the monitor drain; leftovers count as failures
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      $display("FAIL drain: got %0d unchecked entries expected 0", q.size());
      n_checks += q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
